// File: rtl/lcd_cmd_stream_arbiter.sv
// Round-robin packet arbiter feeding the LCD command/pixel FIFO.
// A grant is held from the first word of a packet until its eop beat is accepted.
module lcd_cmd_stream_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int DATA_WIDTH = 10,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_eop,
    input  logic [NUM_SRC-1:0]            src_enable,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_eop,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   cur_idx_q, cur_idx_d;
    logic [IDX_WIDTH-1:0]   last_idx_q, last_idx_d;
    logic [15:0]            pkt_count_q, pkt_count_d;

    logic [NUM_SRC-1:0]     req;
    logic                   found;
    logic [IDX_WIDTH-1:0]   win_idx;
    logic [IDX_WIDTH-1:0]   cand;
    logic [DATA_WIDTH-1:0]  data_arr [NUM_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_data
            assign data_arr[gi] = src_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign req = src_valid & src_enable;

    // Walk the sources starting just after the previous owner; first requester wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = last_idx_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = (cand == IDX_WIDTH'(NUM_SRC - 1)) ? '0 : cand + 1'b1;
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        last_idx_d  = last_idx_q;
        pkt_count_d = pkt_count_q;
        out_valid   = 1'b0;
        out_data    = '0;
        out_eop     = 1'b0;
        src_ready   = '0;
        grant       = '0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = LOCKED;
                    cur_idx_d = win_idx;
                end
            end
            LOCKED: begin
                busy               = 1'b1;
                grant[cur_idx_q]   = 1'b1;
                out_valid          = src_valid[cur_idx_q];
                out_data           = src_valid[cur_idx_q] ? data_arr[cur_idx_q] : '0;
                out_eop            = src_eop[cur_idx_q];
                src_ready[cur_idx_q] = out_ready;
                // Only the accepted eop word releases the grant.
                if (src_valid[cur_idx_q] && out_ready && src_eop[cur_idx_q]) begin
                    state_d     = IDLE;
                    last_idx_d  = cur_idx_q;
                    pkt_count_d = pkt_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_idx_q   <= '0;
            last_idx_q  <= IDX_WIDTH'(NUM_SRC - 1);
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            last_idx_q  <= last_idx_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_lcd_cmd_stream_arbiter.sv
// Bench for lcd_cmd_stream_arbiter: queue-based sources, an owner/round-robin reference model,
// per-source data scoreboards and directed scenarios pinned with literal expectations.
module tb_lcd_cmd_stream_arbiter;
    localparam int N  = 3;
    localparam int DW = 10;

    logic            clk        = 1'b0;
    logic            reset_n    = 1'b0;
    logic [N-1:0]    src_valid  = '0;
    logic [N-1:0]    src_ready;
    logic [N*DW-1:0] src_data   = '0;
    logic [N-1:0]    src_eop    = '0;
    logic [N-1:0]    src_enable = '1;
    logic            out_valid;
    logic            out_ready  = 1'b1;
    logic [DW-1:0]   out_data;
    logic            out_eop;
    logic [N-1:0]    grant;
    logic            busy;
    logic [15:0]     pkt_count;

    lcd_cmd_stream_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .IDX_WIDTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .src_eop(src_eop), .src_enable(src_enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_eop(out_eop), .grant(grant), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: current owner (-1 = nobody), previous owner, completed packets.
    int owner  = -1;
    int last   = N - 1;
    int mcount = 0;

    logic [10:0] wq    [N][$];   // source-side words {eop, data}
    logic [9:0]  exp_q [N][$];   // words each source still expects to see on out_data
    logic [N-1:0] hold = '0;
    int seq [N] = '{1, 1, 1};
    int pct = 100;
    bit fifo_mode  = 1'b0;
    int fifo_cnt   = 0;
    bit rand_ready = 1'b0;
    int grant_log [$];
    int grant_step = 0;
    int step_no    = 0;
    logic [9:0] beat_log [$];
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int s, input int len);
        logic [9:0] d;
        for (int w = 0; w < len; w++) begin
            d = 10'((s << 8) | (seq[s] & 255));
            seq[s]++;
            wq[s].push_back({(w == len - 1), d});
            exp_q[s].push_back(d);
        end
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (wq[i].size() > 0) return 1'b1;
        return owner >= 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!hold[i] && wq[i].size() > 0 && $urandom_range(99) < 32'(pct)) hold[i] = 1'b1;
            src_valid[i] = hold[i];
            if (hold[i]) begin
                src_data[i*DW +: DW] = wq[i][0][9:0];
                src_eop[i]           = wq[i][0][10];
            end else begin
                src_data[i*DW +: DW] = '0;
                src_eop[i]           = 1'b0;
            end
        end
        if (fifo_mode)       out_ready = (fifo_cnt < 8);
        else if (rand_ready) out_ready = ($urandom_range(3) != 0);
        else                 out_ready = 1'b1;
    endtask

    // One cycle: drive at negedge, compare 1 time unit later, advance the model at posedge.
    task automatic step();
        logic [N-1:0] exp_grant, exp_sr, sr_s;
        logic [1:0]   oi;
        logic         exp_ov;
        step_no++;
        drive();
        #1;
        oi        = 2'(owner < 0 ? 0 : owner);
        exp_grant = (owner >= 0) ? 3'(1 << owner) : '0;
        exp_ov    = (owner >= 0) && src_valid[oi];
        exp_sr    = (owner >= 0 && out_ready) ? exp_grant : '0;
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("src_ready", 32'(src_ready), 32'(exp_sr));
        chk("pkt_count", 32'(pkt_count), 32'(mcount));
        if (exp_ov) begin
            chk("out_eop", 32'(out_eop), 32'(src_eop[oi]));
            if (exp_q[oi].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard source %0d actual=0x%0h required=none", owner, out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q[oi][0]));
                if (out_ready) void'(exp_q[oi].pop_front());
            end
        end
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
            grant_step = step_no;
        end
        prev_grant = grant;
        if (out_valid && out_ready) begin
            beat_log.push_back(out_data);
            if (fifo_mode) fifo_cnt++;
        end
        sr_s = src_ready;
        @(posedge clk);
        if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (src_valid[c] && src_enable[c]) begin
                    owner = c;
                    break;
                end
            end
        end else if (src_valid[oi] && out_ready && src_eop[oi]) begin
            last   = owner;
            owner  = -1;
            mcount = (mcount + 1) % 65536;
        end
        for (int i = 0; i < N; i++) begin
            if (hold[i] && sr_s[i]) begin
                void'(wq[i].pop_front());
                hold[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while (any_pending() && n < max) begin
            step();
            n++;
        end
        if (n >= max) begin
            checks++;
            failures++;
            $display("FAIL drain_bound actual=%0d cycles required<%0d", n, max);
        end
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pkt_count", 32'(pkt_count), 32'h0);
        chk("rst_src_ready", 32'(src_ready), 32'h0);
        owner = -1; last = N - 1; mcount = 0;
        hold = '0; src_valid = '0; src_eop = '0; src_data = '0;
        for (int i = 0; i < N; i++) begin
            wq[i].delete();
            exp_q[i].delete();
        end
        prev_grant = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, waited;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset
        repeat (10) step();
        chk("idle_pkt_count", 32'(pkt_count), 32'h0);
        chk("idle_grant", 32'(grant), 32'h0);

        // Source 1 single 4-word packet
        beat_log.delete();
        grant_log.delete();
        n1 = step_no;
        push_pkt(1, 4);
        run_idle(20);
        chk("p2_grants", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0) chk("p2_grant_src", 32'(grant_log[0]), 32'd1);
        chk("p2_grant_latency", 32'(grant_step - n1), 32'd2);
        chk("p2_beats", 32'(beat_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < beat_log.size(); i++)
            chk("p2_word", 32'(beat_log[i]), 32'h101 + 32'(i));
        chk("p2_pkt_count", 32'(pkt_count), 32'd1);

        // All sources, back-to-back 2-word packets
        do_reset();
        grant_log.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) push_pkt(s, 2);
        repeat (17) step();
        chk("p3_pkt_count_17", 32'(pkt_count), 32'd5);
        step();
        chk("p3_pkt_count_18", 32'(pkt_count), 32'd6);
        chk("p3_grants", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("p3_order", 32'(grant_log[i]), 32'(i % 3));
        run_idle(10);

        // 12-word packet into a depth-8 FIFO that is not drained
        fifo_mode = 1'b1;
        fifo_cnt  = 0;
        push_pkt(0, 12);
        repeat (15) step();
        chk("p4_fifo_full", 32'(fifo_cnt), 32'd8);
        chk("p4_stall_ready", 32'(src_ready), 32'h0);
        chk("p4_stall_count", 32'(pkt_count), 32'd6);
        fifo_cnt -= 4;
        run_idle(30);
        chk("p4_fifo_after", 32'(fifo_cnt), 32'd8);
        chk("p4_pkt_count", 32'(pkt_count), 32'd7);
        fifo_mode = 1'b0;

        // Source 1 disabled; then source 0 disabled mid-packet
        src_enable = 3'b101;
        grant_log.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) push_pkt(s, 2);
        repeat (30) step();
        chk("p5_grants", 32'(grant_log.size()), 32'd4);
        push_pkt(0, 3);
        push_pkt(2, 2);
        waited = 0;
        while (prev_grant != 3'b001 && waited < 20) begin
            step();
            waited++;
        end
        chk("p5_wait_grant0", 32'(prev_grant), 32'b001);
        src_enable = 3'b100;
        repeat (6) step();
        chk("p5_src0_complete", 32'(exp_q[0].size()), 32'd0);
        n1 = 0;
        foreach (grant_log[i]) if (grant_log[i] == 1) n1++;
        chk("p5_src1_never", 32'(n1), 32'd0);
        src_enable = 3'b111;
        run_idle(30);
        if (grant_log.size() > 0) chk("p5_src1_last", 32'(grant_log[grant_log.size()-1]), 32'd1);

        // Randomized traffic
        rand_ready = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) pct = $urandom_range(30, 100);
            if (c % 40 == 0) src_enable = 3'($urandom_range(7));
            for (int s = 0; s < N; s++)
                if (wq[s].size() < 4 && $urandom_range(3) == 0) push_pkt(s, $urandom_range(1, 6));
            step();
        end
        src_enable = 3'b111;
        pct = 100;
        run_idle(600);

        // Reset during the third word of a 5-word packet
        rand_ready = 1'b0;
        beat_log.delete();
        push_pkt(0, 5);
        waited = 0;
        while (beat_log.size() < 2 && waited < 20) begin
            step();
            waited++;
        end
        chk("p6_two_beats", 32'(beat_log.size()), 32'd2);
        drive();
        #1;
        chk("p6_mid_valid", 32'(out_valid), 32'h1);
        do_reset();
        grant_log.delete();
        for (int s = 0; s < N; s++) push_pkt(s, 1);
        run_idle(20);
        chk("p6_grants", 32'(grant_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < grant_log.size(); i++)
            chk("p6_order", 32'(grant_log[i]), 32'(i));
        chk("p6_pkt_count", 32'(pkt_count), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
